// File: rtl/tcdm_bank_ram_if.sv
// Request/response bundle of the TCDM bank RAM: request valid/grant,
// write enable, byte enables, write data, word address, and the response
// valid/data/error triple.
interface tcdm_bank_ram_if #(
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned ADDR_WIDTH = 10
);
    logic                    req;
    logic                    gnt;
    logic                    wr_en;
    logic [DATA_WIDTH/8-1:0] ben;
    logic [DATA_WIDTH-1:0]   wdata;
    logic [ADDR_WIDTH-1:0]   addr;
    logic                    rvalid;
    logic [DATA_WIDTH-1:0]   rdata;
    logic                    err;

    modport master (
        output req, wr_en, ben, wdata, addr,
        input  gnt, rvalid, rdata, err
    );

    modport slave (
        input  req, wr_en, ben, wdata, addr,
        output gnt, rvalid, rdata, err
    );
endinterface

// File: rtl/tcdm_bank_ram.sv
// Single-port TCDM bank RAM with a power-up clear sweep, byte-enabled
// writes, out-of-range error responses and an optional response register.
module tcdm_bank_ram #(
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned ADDR_WIDTH = 10,
    parameter int unsigned DATA_DEPTH = 1024,
    parameter int unsigned OUT_REGS   = 0
) (
    input  logic                    Clk_CI,
    input  logic                    Rst_RBI,
    input  logic                    Req_SI,
    output logic                    Gnt_SO,
    input  logic                    WrEn_SI,
    input  logic [DATA_WIDTH/8-1:0] BEn_SI,
    input  logic [DATA_WIDTH-1:0]   WrData_DI,
    input  logic [ADDR_WIDTH-1:0]   Addr_DI,
    output logic                    RValid_SO,
    output logic [DATA_WIDTH-1:0]   RdData_DO,
    output logic                    Err_SO,
    output logic                    InitDone_SO
);

    localparam int unsigned BE_WIDTH  = DATA_WIDTH / 8;
    localparam int unsigned IDX_WIDTH = (DATA_DEPTH > 1) ? $clog2(DATA_DEPTH) : 1;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DATA_DEPTH - 1);
    localparam logic [ADDR_WIDTH:0]   DEPTH_EXT = (ADDR_WIDTH + 1)'(DATA_DEPTH);

    if (DATA_WIDTH < 8 || (DATA_WIDTH % 8) != 0) begin : gen_err_width
        $error("tcdm_bank_ram: DATA_WIDTH must be a multiple of 8 and at least 8");
    end
    if (DATA_DEPTH < 1 || 64'(DATA_DEPTH) > (64'd1 << ADDR_WIDTH)) begin : gen_err_depth
        $error("tcdm_bank_ram: DATA_DEPTH must be between 1 and 2**ADDR_WIDTH");
    end
    if (OUT_REGS > 1) begin : gen_err_out_regs
        $error("tcdm_bank_ram: OUT_REGS must be 0 or 1");
    end

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_e;

    state_e                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   sweep_addr_q, sweep_addr_d;

    logic                    gnt;
    logic                    in_range;
    logic [IDX_WIDTH-1:0]    req_idx;

    logic [BE_WIDTH-1:0]     mem_we;
    logic [IDX_WIDTH-1:0]    mem_widx;
    logic [DATA_WIDTH-1:0]   mem_wdata;
    logic [DATA_WIDTH-1:0]   mem_q [DATA_DEPTH];

    logic                    rsp_valid_q, rsp_valid_d;
    logic                    rsp_err_q, rsp_err_d;
    logic [DATA_WIDTH-1:0]   rsp_data_q, rsp_data_d;

    assign in_range = ({1'b0, Addr_DI} < DEPTH_EXT);
    assign req_idx  = Addr_DI[IDX_WIDTH-1:0];

    // State and sweep pointer registers; reset restarts the clear sweep.
    always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
        if (!Rst_RBI) begin
            state_q      <= INIT;
            sweep_addr_q <= '0;
        end else begin
            state_q      <= state_d;
            sweep_addr_q <= sweep_addr_d;
        end
    end

    // Walk the sweep pointer through every word, then hand over to RUN.
    always_comb begin
        state_d      = state_q;
        sweep_addr_d = sweep_addr_q;
        case (state_q)
            INIT: begin
                if (sweep_addr_q == LAST_ADDR) begin
                    state_d      = RUN;
                    sweep_addr_d = '0;
                end else begin
                    sweep_addr_d = sweep_addr_q + 1'b1;
                end
            end
            RUN: begin
                state_d = RUN;
            end
            default: begin
                state_d = INIT;
            end
        endcase
    end

    // Grant and init-done only once the sweep has finished; requests stall in INIT.
    always_comb begin
        gnt         = 1'b0;
        InitDone_SO = 1'b0;
        if (state_q == RUN) begin
            gnt         = Req_SI;
            InitDone_SO = 1'b1;
        end
    end

    assign Gnt_SO = gnt;

    // Select the single write port source: sweep clears whole words, requests use byte enables.
    always_comb begin
        mem_we    = '0;
        mem_widx  = sweep_addr_q[IDX_WIDTH-1:0];
        mem_wdata = '0;
        if (state_q == INIT) begin
            mem_we = '1;
        end else if (gnt && WrEn_SI && in_range) begin
            mem_we    = BEn_SI;
            mem_widx  = req_idx;
            mem_wdata = WrData_DI;
        end
    end

    // Storage array, written byte by byte; contents are defined by the sweep, not by reset.
    always_ff @(posedge Clk_CI) begin
        for (int b = 0; b < BE_WIDTH; b++) begin
            if (mem_we[b]) begin
                mem_q[mem_widx][8*b +: 8] <= mem_wdata[8*b +: 8];
            end
        end
    end

    // Build the first response stage; data holds its last value between responses.
    always_comb begin
        rsp_valid_d = gnt;
        rsp_err_d   = gnt && !in_range;
        rsp_data_d  = rsp_data_q;
        if (gnt) begin
            rsp_data_d = (!WrEn_SI && in_range) ? mem_q[req_idx] : '0;
        end
    end

    // First response register; reset drops any response in flight.
    always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
        if (!Rst_RBI) begin
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_data_q  <= '0;
        end else begin
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_data_q  <= rsp_data_d;
        end
    end

    if (OUT_REGS == 1) begin : gen_out_reg
        logic                  out_valid_q, out_valid_d;
        logic                  out_err_q, out_err_d;
        logic [DATA_WIDTH-1:0] out_data_q, out_data_d;

        // Second stage follows the first, holding data while no response moves through.
        always_comb begin
            out_valid_d = rsp_valid_q;
            out_err_d   = rsp_err_q;
            out_data_d  = rsp_valid_q ? rsp_data_q : out_data_q;
        end

        // Extra response register keeping valid, error and data aligned.
        always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
            if (!Rst_RBI) begin
                out_valid_q <= 1'b0;
                out_err_q   <= 1'b0;
                out_data_q  <= '0;
            end else begin
                out_valid_q <= out_valid_d;
                out_err_q   <= out_err_d;
                out_data_q  <= out_data_d;
            end
        end

        assign RValid_SO = out_valid_q;
        assign Err_SO    = out_err_q;
        assign RdData_DO = out_data_q;
    end else begin : gen_no_out_reg
        assign RValid_SO = rsp_valid_q;
        assign Err_SO    = rsp_err_q;
        assign RdData_DO = rsp_data_q;
    end

endmodule

// File: tb/tb_tcdm_bank_ram.sv
// Bench for tcdm_bank_ram: one instance without and one with the output
// register, driven in lockstep from a vector table plus reset sequences,
// with per-instance scoreboards checking data, error flag and latency.
module tb_tcdm_bank_ram;

    localparam int DW    = 64;
    localparam int AW    = 5;
    localparam int DEPTH = 16;
    localparam int BW    = DW / 8;
    localparam int NVEC  = 24;

    logic clk = 1'b0;
    logic rst_n;
    logic init_done0, init_done1;

    always #5 clk = ~clk;

    tcdm_bank_ram_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus0 ();
    tcdm_bank_ram_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus1 ();

    tcdm_bank_ram #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DATA_DEPTH(DEPTH), .OUT_REGS(0)
    ) dut0 (
        .Clk_CI(clk), .Rst_RBI(rst_n),
        .Req_SI(bus0.req), .Gnt_SO(bus0.gnt), .WrEn_SI(bus0.wr_en),
        .BEn_SI(bus0.ben), .WrData_DI(bus0.wdata), .Addr_DI(bus0.addr),
        .RValid_SO(bus0.rvalid), .RdData_DO(bus0.rdata), .Err_SO(bus0.err),
        .InitDone_SO(init_done0)
    );

    tcdm_bank_ram #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DATA_DEPTH(DEPTH), .OUT_REGS(1)
    ) dut1 (
        .Clk_CI(clk), .Rst_RBI(rst_n),
        .Req_SI(bus1.req), .Gnt_SO(bus1.gnt), .WrEn_SI(bus1.wr_en),
        .BEn_SI(bus1.ben), .WrData_DI(bus1.wdata), .Addr_DI(bus1.addr),
        .RValid_SO(bus1.rvalid), .RdData_DO(bus1.rdata), .Err_SO(bus1.err),
        .InitDone_SO(init_done1)
    );

    typedef struct {
        logic [DW-1:0] data;
        logic          err;
        int            due;
    } exp_t;

    typedef struct {
        logic          wr;
        logic [BW-1:0] ben;
        logic [DW-1:0] wdata;
        logic [AW-1:0] addr;
        logic [DW-1:0] exp_data;
        logic          exp_err;
    } vec_t;

    exp_t          q0[$];
    exp_t          q1[$];
    vec_t          vecs[NVEC];
    logic [DW-1:0] last_rsp[2];
    int            cyc    = 0;
    int            n_vec  = 0;
    int            n_miss = 0;
    logic          mon_en = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("[TB] FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic setInputs(input logic req, input logic wr, input logic [BW-1:0] ben,
                             input logic [DW-1:0] wdata, input logic [AW-1:0] addr);
        bus0.req = req; bus0.wr_en = wr; bus0.ben = ben; bus0.wdata = wdata; bus0.addr = addr;
        bus1.req = req; bus1.wr_en = wr; bus1.ben = ben; bus1.wdata = wdata; bus1.addr = addr;
    endtask

    task automatic applyStimulus(input vec_t v);
        setInputs(1'b1, v.wr, v.ben, v.wdata, v.addr);
        #1;
        checkOutput("dut0 gnt", {63'd0, bus0.gnt}, 64'd1);
        checkOutput("dut1 gnt", {63'd0, bus1.gnt}, 64'd1);
        q0.push_back('{data: v.exp_data, err: v.exp_err, due: cyc + 1});
        q1.push_back('{data: v.exp_data, err: v.exp_err, due: cyc + 2});
        @(posedge clk);
        #1;
    endtask

    task automatic waitInit();
        checkOutput("gnt at release", {62'd0, bus0.gnt, bus1.gnt}, 64'd0);
        for (int k = 1; k <= DEPTH; k++) begin
            @(posedge clk);
            #1;
            checkOutput($sformatf("sweep gnt k=%0d", k), {62'd0, bus0.gnt, bus1.gnt},
                        (k == DEPTH) ? 64'd3 : 64'd0);
            checkOutput($sformatf("sweep init_done k=%0d", k), {62'd0, init_done0, init_done1},
                        (k == DEPTH) ? 64'd3 : 64'd0);
        end
    endtask

    task automatic monitorDut(input int d, input logic rvalid, input logic [DW-1:0] rdata, input logic err);
        exp_t e;
        logic have;
        have = (d == 0) ? (q0.size() > 0) : (q1.size() > 0);
        if (have) e = (d == 0) ? q0[0] : q1[0];
        if (!rst_n) begin
            checkOutput($sformatf("dut%0d reset rvalid", d), {63'd0, rvalid}, 64'd0);
            checkOutput($sformatf("dut%0d reset rdata", d), rdata, 64'd0);
            checkOutput($sformatf("dut%0d reset err", d), {63'd0, err}, 64'd0);
            last_rsp[d] = '0;
        end else if (rvalid) begin
            if (!have) begin
                n_vec++;
                n_miss++;
                $display("[TB] FAIL dut%0d unexpected response: got data %h err %0b, expected none (cycle %0d)",
                         d, rdata, err, cyc);
            end else begin
                if (d == 0) void'(q0.pop_front()); else void'(q1.pop_front());
                checkOutput($sformatf("dut%0d rdata", d), rdata, e.data);
                checkOutput($sformatf("dut%0d err", d), {63'd0, err}, {63'd0, e.err});
                checkOutput($sformatf("dut%0d latency cycle", d), 64'(cyc), 64'(e.due));
                last_rsp[d] = e.data;
            end
        end else begin
            checkOutput($sformatf("dut%0d idle err", d), {63'd0, err}, 64'd0);
            checkOutput($sformatf("dut%0d idle rdata hold", d), rdata, last_rsp[d]);
            if (have && e.due <= cyc) begin
                n_vec++;
                n_miss++;
                $display("[TB] FAIL dut%0d missing response: got none, expected data %h due cycle %0d",
                         d, e.data, e.due);
                if (d == 0) void'(q0.pop_front()); else void'(q1.pop_front());
            end
        end
    endtask

    // Compare both instances' responses against their scoreboards mid-cycle.
    always @(negedge clk) begin
        if (mon_en) begin
            monitorDut(0, bus0.rvalid, bus0.rdata, bus0.err);
            monitorDut(1, bus1.rvalid, bus1.rdata, bus1.err);
        end
    end

    initial begin
        last_rsp[0] = '0;
        last_rsp[1] = '0;

        vecs[0]  = '{1'b0, 8'h00, 64'h0,                  5'd0,  64'h0,                  1'b0};
        vecs[1]  = '{1'b1, 8'h0F, 64'h1122334455667788,   5'd3,  64'h0,                  1'b0};
        vecs[2]  = '{1'b0, 8'h00, 64'h0,                  5'd3,  64'h0000000055667788,   1'b0};
        vecs[3]  = '{1'b1, 8'hFF, 64'hA5A5A5A5A5A5A5A5,   5'd4,  64'h0,                  1'b0};
        vecs[4]  = '{1'b0, 8'h00, 64'h0,                  5'd20, 64'h0,                  1'b1};
        vecs[5]  = '{1'b0, 8'h00, 64'h0,                  5'd4,  64'hA5A5A5A5A5A5A5A5,   1'b0};
        vecs[6]  = '{1'b1, 8'h00, 64'hFFFFFFFFFFFFFFFF,   5'd4,  64'h0,                  1'b0};
        vecs[7]  = '{1'b0, 8'h00, 64'h0,                  5'd4,  64'hA5A5A5A5A5A5A5A5,   1'b0};
        vecs[8]  = '{1'b1, 8'hFF, 64'hDEADBEEFDEADBEEF,   5'd20, 64'h0,                  1'b1};
        vecs[9]  = '{1'b0, 8'h00, 64'h0,                  5'd4,  64'hA5A5A5A5A5A5A5A5,   1'b0};
        vecs[10] = '{1'b1, 8'hF0, 64'h0123456789ABCDEF,   5'd7,  64'h0,                  1'b0};
        vecs[11] = '{1'b0, 8'h00, 64'h0,                  5'd7,  64'h0123456700000000,   1'b0};
        vecs[12] = '{1'b1, 8'h80, 64'hEE00000000000000,   5'd3,  64'h0,                  1'b0};
        vecs[13] = '{1'b0, 8'h00, 64'h0,                  5'd3,  64'hEE00000055667788,   1'b0};
        vecs[14] = '{1'b0, 8'h00, 64'h0,                  5'd15, 64'h0,                  1'b0};
        vecs[15] = '{1'b0, 8'h00, 64'h0,                  5'd31, 64'h0,                  1'b1};
        vecs[16] = '{1'b0, 8'h00, 64'h0,                  5'd0,  64'h0,                  1'b0};
        vecs[17] = '{1'b0, 8'h00, 64'h0,                  5'd1,  64'h0,                  1'b0};
        vecs[18] = '{1'b0, 8'h00, 64'h0,                  5'd2,  64'h0,                  1'b0};
        vecs[19] = '{1'b0, 8'h00, 64'h0,                  5'd3,  64'hEE00000055667788,   1'b0};
        vecs[20] = '{1'b0, 8'h00, 64'h0,                  5'd4,  64'hA5A5A5A5A5A5A5A5,   1'b0};
        vecs[21] = '{1'b0, 8'h00, 64'h0,                  5'd5,  64'h0,                  1'b0};
        vecs[22] = '{1'b0, 8'h00, 64'h0,                  5'd6,  64'h0,                  1'b0};
        vecs[23] = '{1'b0, 8'h00, 64'h0,                  5'd7,  64'h0123456700000000,   1'b0};

        rst_n = 1'b1;
        setInputs(1'b1, 1'b0, '0, '0, '0);
        #2;
        rst_n  = 1'b0;
        mon_en = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset gnt", {62'd0, bus0.gnt, bus1.gnt}, 64'd0);
        checkOutput("reset init_done", {62'd0, init_done0, init_done1}, 64'd0);

        @(posedge clk);
        #3;
        rst_n = 1'b1;
        $display("[TB] reset released, waiting for clear sweep");
        waitInit();

        for (int i = 0; i < NVEC; i++) begin
            applyStimulus(vecs[i]);
        end
        setInputs(1'b0, 1'b0, '0, '0, '0);
        repeat (4) @(posedge clk);
        #1;

        $display("[TB] reset during an in-flight write response");
        setInputs(1'b1, 1'b1, 8'hFF, 64'hFFFFFFFFFFFFFFFF, 5'd5);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        setInputs(1'b1, 1'b0, '0, '0, 5'd5);
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b1;
        waitInit();
        applyStimulus('{1'b0, 8'h00, 64'h0, 5'd5, 64'h0, 1'b0});
        setInputs(1'b0, 1'b0, '0, '0, '0);
        repeat (4) @(posedge clk);
        #1;

        checkOutput("dut0 outstanding responses", 64'(q0.size()), 64'd0);
        checkOutput("dut1 outstanding responses", 64'(q1.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
